// File: rtl/gmii_router_definitions.sv
// Shared router types: per-port MAC learn record, GMII RX parser states and
// framing constants.
// No ports (package).
package gmii_router_definitions;

  localparam logic [47:0] BROADCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Learn record handed to the per-port clock converter.
  typedef struct packed {
    logic        mac_valid;
    logic [47:0] mac_number_per_port;
  } mac_info_interface;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    DROP
  } gmii_rx_state_t;

endpackage

// File: rtl/gmii_rx_mac_extractor.sv
// Per-port GMII RX parser: strips preamble/SFD, captures DA and SA, emits an
// early DA pulse for lookup, a learn pulse for well-formed unicast-source
// frames, and a saturating count of rejected frames.
// Ports: clk/rst_n (port RX clock, async active-low reset); gmii_rxd/
// gmii_rx_dv/gmii_rx_er (GMII receive); mac_info (learn pulse + SA);
// dst_valid/dst_mac (DA pulse + DA); drop_count (rejected frames).
module gmii_rx_mac_extractor
  import gmii_router_definitions::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int MAX_PREAMBLE  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        gmii_rxd,
  input  logic              gmii_rx_dv,
  input  logic              gmii_rx_er,
  output mac_info_interface mac_info,
  output logic              dst_valid,
  output logic [47:0]       dst_mac,
  output logic [15:0]       drop_count
);

  // Byte counter must hold MAX_FRAME_LEN+1 (its saturation value).
  localparam int BCW = $clog2(MAX_FRAME_LEN + 2);
  localparam int PCW = $clog2(MAX_PREAMBLE + 1);

  localparam logic [BCW-1:0] BC_MIN     = BCW'(MIN_FRAME_LEN);
  localparam logic [BCW-1:0] BC_MAX     = BCW'(MAX_FRAME_LEN);
  localparam logic [BCW-1:0] BC_SAT     = BCW'(MAX_FRAME_LEN + 1);
  localparam logic [BCW-1:0] BC_DA_LAST = BCW'(5);
  localparam logic [BCW-1:0] BC_SA_LAST = BCW'(11);
  localparam logic [PCW-1:0] PCNT_MAX   = PCW'(MAX_PREAMBLE);

  gmii_rx_state_t state_q, state_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic           err_q, err_d;
  logic [47:0]    dst_q, dst_d;
  logic [47:0]    src_q, src_d;       // SA shadow, only published on learn
  logic [47:0]    mac_q, mac_d;
  logic           mac_vld_q, mac_vld_d;
  logic           dst_vld_q, dst_vld_d;
  logic [15:0]    drop_q, drop_d;
  logic           drop_inc;
  logic           er_hit;
  logic           learn_ok;

  // rx_er only counts while rx_dv is high; with rx_dv low it signals
  // carrier extension / false carrier and is not a frame error.
  assign er_hit = gmii_rx_dv & gmii_rx_er;

  // src_q[40] is the I/G bit: group (multicast/broadcast) sources are never learned.
  assign learn_ok = (bc_q >= BC_MIN) && (bc_q <= BC_MAX) && !err_q && !src_q[40];

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    bc_d      = bc_q;
    err_d     = err_q;
    dst_d     = dst_q;
    src_d     = src_q;
    mac_d     = mac_q;
    mac_vld_d = 1'b0;
    dst_vld_d = 1'b0;
    drop_inc  = 1'b0;

    case (state_q)
      IDLE: begin
        err_d  = er_hit;
        pcnt_d = '0;
        if (gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE_BYTE) begin
            state_d = PREAMBLE;
            pcnt_d  = PCW'(1);
          end else if (gmii_rxd == SFD_BYTE) begin
            state_d = HEADER;
            bc_d    = '0;
          end else begin
            state_d = DROP;
          end
        end
      end

      PREAMBLE: begin
        err_d = err_q | er_hit;
        if (!gmii_rx_dv) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end else if (gmii_rxd == PREAMBLE_BYTE && pcnt_q < PCNT_MAX) begin
          pcnt_d = pcnt_q + PCW'(1);
        end else if (gmii_rxd == SFD_BYTE) begin
          state_d = HEADER;
          bc_d    = '0;
        end else begin
          state_d = DROP;
        end
      end

      HEADER: begin
        if (!gmii_rx_dv) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end else begin
          err_d = err_q | er_hit;
          if (bc_q <= BC_DA_LAST) begin
            dst_d = {dst_q[39:0], gmii_rxd};
          end else begin
            src_d = {src_q[39:0], gmii_rxd};
          end
          dst_vld_d = (bc_q == BC_DA_LAST);
          bc_d      = bc_q + BCW'(1);
          if (bc_q == BC_SA_LAST) begin
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
          if (learn_ok) begin
            mac_vld_d = 1'b1;
            mac_d     = src_q;
          end else begin
            drop_inc = 1'b1;
          end
        end else begin
          err_d = err_q | er_hit;
          if (bc_q != BC_SAT) begin
            bc_d = bc_q + BCW'(1);
          end
        end
      end

      DROP: begin
        if (!gmii_rx_dv) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      bc_q      <= '0;
      err_q     <= 1'b0;
      dst_q     <= '0;
      src_q     <= '0;
      mac_q     <= '0;
      mac_vld_q <= 1'b0;
      dst_vld_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      bc_q      <= bc_d;
      err_q     <= err_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      mac_q     <= mac_d;
      mac_vld_q <= mac_vld_d;
      dst_vld_q <= dst_vld_d;
      drop_q    <= drop_d;
    end
  end

  assign mac_info.mac_valid           = mac_vld_q;
  assign mac_info.mac_number_per_port = mac_q;
  assign dst_valid                    = dst_vld_q;
  assign dst_mac                      = dst_q;
  assign drop_count                   = drop_q;

endmodule

// File: tb/tb_gmii_rx_mac_extractor.sv
// Directed bench for gmii_rx_mac_extractor: table of whole frames with
// expected pulses/counters, plus hand-written multi-frame and reset sequences.
module tb_gmii_rx_mac_extractor;
  import gmii_router_definitions::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        gmii_rxd;
  logic              gmii_rx_dv;
  logic              gmii_rx_er;
  mac_info_interface mac_info;
  logic              dst_valid;
  logic [47:0]       dst_mac;
  logic [15:0]       drop_count;

  gmii_rx_mac_extractor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .mac_info   (mac_info),
    .dst_valid  (dst_valid),
    .dst_mac    (dst_mac),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  localparam logic [47:0] SA1 = 48'h0211_2233_4455;
  localparam logic [47:0] SA2 = 48'h00AA_BBCC_DDEE;
  localparam logic [47:0] SAM = 48'h0100_5E00_0001;
  localparam logic [47:0] DA2 = 48'h0A1B_2C3D_4E5F;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int dv_cnt, mv_cnt, dv_cyc, mv_cyc;
  int da5_pos, da5_cyc, eof_cyc;
  logic [15:0] drop_at_eof;
  logic [7:0]  stream[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (dst_valid) begin
      if (dv_cnt == 0) dv_cyc = cyc;
      dv_cnt++;
    end
    if (mac_info.mac_valid) begin
      if (mv_cnt == 0) mv_cyc = cyc;
      mv_cnt++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_mv"},   48'(mac_info.mac_valid), 48'd0);
    chk({nm, "_mac"},  mac_info.mac_number_per_port, 48'd0);
    chk({nm, "_dv"},   48'(dst_valid), 48'd0);
    chk({nm, "_dst"},  dst_mac, 48'd0);
    chk({nm, "_drop"}, 48'(drop_count), 48'd0);
  endtask

  task automatic clear_mon();
    dv_cnt = 0; mv_cnt = 0; dv_cyc = -1; mv_cyc = -1;
  endtask

  task automatic idle(input int n);
    gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Asserted between edges so the zero check proves the clear is asynchronous.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #2;
    chk_zero(nm);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    clear_mon();
  endtask

  task automatic build(input int npre, input logic [47:0] da, input logic [47:0] sa, input int len);
    logic [7:0] b;
    stream.delete();
    for (int i = 0; i < npre; i++) stream.push_back(PREAMBLE_BYTE);
    stream.push_back(SFD_BYTE);
    for (int i = 0; i < len; i++) begin
      if (i < 6)       b = da[47 - 8*i -: 8];
      else if (i < 12) b = sa[47 - 8*(i-6) -: 8];
      else             b = 8'hA0 ^ i[7:0];
      stream.push_back(b);
    end
    da5_pos = (len >= 6) ? npre + 6 : -1;
  endtask

  // Drives the stream, then one rx_dv=0 cycle. rst_pos >= 0 pulls reset low
  // for two cycles starting at that stream byte.
  task automatic play(input int er_pos, input int rst_pos);
    da5_cyc = -1;
    foreach (stream[k]) begin
      gmii_rxd   = stream[k];
      gmii_rx_dv = 1'b1;
      gmii_rx_er = (k == er_pos);
      if (k == da5_pos) da5_cyc = cyc;
      if (rst_pos >= 0 && k == rst_pos) begin
        rst_n = 1'b0;
        #2;
        chk_zero("rst_mid");
      end
      if (rst_pos >= 0 && k == rst_pos + 2) rst_n = 1'b1;
      @(posedge clk); #1;
    end
    drop_at_eof = drop_count;
    eof_cyc     = cyc;
    idle(1);
  endtask

  typedef struct {
    int          npre;
    logic [47:0] da;
    logic [47:0] sa;
    int          len;
    int          er_pos;
    bit          exp_dv;
    bit          exp_mv;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs[15];

  initial begin
    rst_n = 1'b0; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
    clear_mon();
    #1;

    //        npre da         sa   len   er    dv mv drop
    vecs[0]  = '{7, BROADCAST, SA1,   64,   -1, 1, 1, 16'd0};
    vecs[1]  = '{7, BROADCAST, SA1,   40,   -1, 1, 0, 16'd1};
    vecs[2]  = '{7, BROADCAST, SA1,  100, 8+30, 1, 0, 16'd1};
    vecs[3]  = '{7, BROADCAST, SAM,   64,   -1, 1, 0, 16'd1};
    vecs[4]  = '{7, BROADCAST, SA1, 1600,   -1, 1, 0, 16'd1};
    vecs[5]  = '{7, DA2,       SA1, 1522,   -1, 1, 1, 16'd0};
    vecs[6]  = '{7, DA2,       SA1, 1523,   -1, 1, 0, 16'd1};
    vecs[7]  = '{7, DA2,       SA1,   63,   -1, 1, 0, 16'd1};
    vecs[8]  = '{0, DA2,       SA2,   64,   -1, 1, 1, 16'd0};
    vecs[9]  = '{8, DA2,       SA1,   64,   -1, 0, 0, 16'd1};
    vecs[10] = '{7, DA2,       SA1,    8,   -1, 1, 0, 16'd1};
    vecs[11] = '{7, DA2,       SA1,   64,    2, 1, 0, 16'd1};
    vecs[12] = '{1, DA2,       SA1,    5,   -1, 0, 0, 16'd1};
    vecs[13] = '{7, DA2,       SA2,   65,   -1, 1, 1, 16'd0};
    vecs[14] = '{7, DA2,       SA1,   64, 8+63, 1, 0, 16'd1};

    for (int i = 0; i < 15; i++) begin
      do_reset($sformatf("v%0d_rst", i));
      build(vecs[i].npre, vecs[i].da, vecs[i].sa, vecs[i].len);
      play(vecs[i].er_pos, -1);
      idle(3);
      chk($sformatf("v%0d_dv_cnt", i), 48'(dv_cnt), 48'(vecs[i].exp_dv));
      chk($sformatf("v%0d_mv_cnt", i), 48'(mv_cnt), 48'(vecs[i].exp_mv));
      chk($sformatf("v%0d_drop", i), 48'(drop_count), 48'(vecs[i].exp_drop));
      chk($sformatf("v%0d_mac", i), mac_info.mac_number_per_port,
          vecs[i].exp_mv ? vecs[i].sa : 48'd0);
      if (vecs[i].exp_dv) begin
        chk($sformatf("v%0d_dst", i), dst_mac, vecs[i].da);
        chk($sformatf("v%0d_dv_lat", i), 48'(dv_cyc - da5_cyc), 48'd1);
      end
      if (vecs[i].exp_mv) begin
        chk($sformatf("v%0d_mv_lat", i), 48'(mv_cyc - eof_cyc), 48'd1);
      end
    end

    // Bad preamble: counted once, only when rx_dv falls; then a jabber frame.
    do_reset("bp_rst");
    stream.delete();
    stream.push_back(8'h55); stream.push_back(8'h55); stream.push_back(8'h57);
    for (int i = 0; i < 5; i++) stream.push_back(8'h10 + 8'(i));
    da5_pos = -1;
    play(-1, -1);
    chk("bp_drop_before_fall", 48'(drop_at_eof), 48'd0);
    idle(2);
    chk("bp_drop", 48'(drop_count), 48'd1);
    chk("bp_dv_cnt", 48'(dv_cnt), 48'd0);
    build(7, BROADCAST, SA1, 1600);
    play(-1, -1);
    idle(3);
    chk("jab_mv_cnt", 48'(mv_cnt), 48'd0);
    chk("jab_drop", 48'(drop_count), 48'd2);

    // Errored frame, one idle cycle, good frame; then two good frames back to back.
    do_reset("b2b_rst");
    build(7, BROADCAST, SA1, 100);
    play(8 + 30, -1);
    build(7, DA2, SA2, 64);
    play(-1, -1);
    idle(3);
    chk("err_then_good_mv_cnt", 48'(mv_cnt), 48'd1);
    chk("err_then_good_mac", mac_info.mac_number_per_port, SA2);
    chk("err_then_good_drop", 48'(drop_count), 48'd1);
    clear_mon();
    build(7, BROADCAST, SA1, 64);
    play(-1, -1);
    build(7, BROADCAST, SA2, 64);
    play(-1, -1);
    idle(3);
    chk("b2b_mv_cnt", 48'(mv_cnt), 48'd2);
    chk("b2b_mac", mac_info.mac_number_per_port, SA2);
    chk("b2b_drop", 48'(drop_count), 48'd1);

    // Reset at payload byte 20 of a frame, with nonzero outputs beforehand.
    do_reset("rm_rst");
    build(7, BROADCAST, SA1, 64);
    play(-1, -1);
    build(7, BROADCAST, SA1, 20);
    play(-1, -1);
    idle(2);
    chk("rm_pre_mac", mac_info.mac_number_per_port, SA1);
    chk("rm_pre_drop", 48'(drop_count), 48'd1);
    clear_mon();
    build(7, DA2, SA2, 64);
    play(-1, 8 + 20);
    idle(3);
    chk("rm_mv_cnt", 48'(mv_cnt), 48'd0);
    chk("rm_drop", 48'(drop_count), 48'd1);
    chk("rm_mac", mac_info.mac_number_per_port, 48'd0);
    build(7, BROADCAST, SA1, 64);
    play(-1, -1);
    idle(3);
    chk("rm_next_mv_cnt", 48'(mv_cnt), 48'd1);
    chk("rm_next_mac", mac_info.mac_number_per_port, SA1);
    chk("rm_next_drop", 48'(drop_count), 48'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
